// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the receiver and transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 193;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchronizer for an asynchronous input, preset to 1 on reset.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[N-2:0], d};
  always_ff @(posedge clk or negedge reset)
    if (!reset) ff_q <= '1;
    else ff_q <= ff_d;
  assign q = ff_q[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a single-entry valid/ready output buffer.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit after data bit 7).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      parity_err,
  output logic                      busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
  logic armed_q, armed_d, valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  logic rx_s, tick, stop_smp, par_bad, good, load;
  uart_sync #(.N(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(rx), .q(rx_s));
  assign tick = cnt_q == LAST;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, pe_q, pe_d;
  assign par_bad = ^{sh_q, par_q};
`else
  assign par_bad = 1'b0;
`endif
  // armed_q blocks re-triggering on a held-low line until it has been seen high
  always_comb begin
    state_d  = state_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    armed_d  = armed_q;
    stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) state_d = START;
      end
      START: begin
        cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
        if (cnt_q == HALF) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          stop_smp = 1'b1;
          state_d  = IDLE;
          armed_d  = rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    good    = stop_smp && rx_s && !par_bad;
    load    = good && (!valid_q || rx_ready);
    data_d  = load ? sh_q : data_q;
    valid_d = load | (valid_q & ~rx_ready);
    fe_d    = stop_smp & ~rx_s;
    ov_d    = good & valid_q & ~rx_ready;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
`ifdef UART_RX_PARITY_EN
  assign pe_d = stop_smp & rx_s & par_bad;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = fe_q;
  assign overrun_err = ov_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun_err, parity_err, busy;
  int n_vec = 0, n_err = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_pe = 0, exp_ov = 0;
  logic [7:0] got_q[$], exp_q[$];
  bit model_full = 1'b0;
  always #5 clk = ~clk;
  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun_err(overrun_err),
    .parity_err(parity_err), .busy(busy)
  );
  always @(negedge clk)
    if (reset) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      fe_cnt += int'(frame_err);
      pe_cnt += int'(parity_err);
      ov_cnt += int'(overrun_err);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit, input int nbits);
    logic [10:0] bits;
    int len;
    len  = PAR ? 11 : 10;
    bits = PAR ? {stop_bit, par_bit, b, 1'b0} : {1'b0, stop_bit, b, 1'b0};
    for (int i = 0; i < len && i < nbits; i++) begin
      rx = bits[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask
  task automatic frame(input logic [7:0] b, input logic stop_ok, input logic par_ok, input logic rdy);
    rx_ready = rdy;
    if (rdy) model_full = 1'b0;
    send_frame(b, stop_ok, (^b) ^ !par_ok, 99);
    if (!stop_ok) exp_fe++;
    else if (PAR && !par_ok) exp_pe++;
    else if (model_full) exp_ov++;
    else begin
      exp_q.push_back(b);
      model_full = !rdy;
    end
  endtask
  task automatic settle(input string tag);
    tick(4);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    chk({tag, "_frame_err"}, fe_cnt, exp_fe);
    chk({tag, "_parity_err"}, pe_cnt, exp_pe);
    chk({tag, "_overrun_err"}, ov_cnt, exp_ov);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_data"}, rx_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_errs"}, {frame_err, overrun_err, parity_err}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] b;
    logic s_ok, p_ok, rdy;
    tick(3);
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick(5);
    frame(8'h55, 1, 1, 1);
    frame(8'hA3, 1, 1, 1);
    settle("pair");
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    chk("glitch_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin
      tick(1);
      n++;
    end
    chk("glitch_idle_in_8", 32'(n <= 8), 1);
    settle("glitch");
    frame(8'h3C, 0, 1, 1);
    chk("ferr_valid", rx_valid, 0);
    tick(2 * CPB);
    settle("ferr");
    rx = 1'b0;
    tick(12 * CPB);
    exp_fe++;
    rx = 1'b1;
    tick(2 * CPB);
    settle("break");
    frame(8'h96, 1, 1, 1);
    settle("after_break");
    frame(8'h11, 1, 1, 0);
    frame(8'h22, 1, 1, 0);
    tick(2);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_pulse", ov_cnt, exp_ov);
    rx_ready = 1'b1;
    model_full = 1'b0;
    tick(1);
    chk("ovr_valid_drop", rx_valid, 0);
    settle("ovr");
    send_frame(8'hF0, 1, 0, 5);
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick(3);
    reset = 1'b1;
    tick(4);
    frame(8'h7E, 1, 1, 1);
    settle("midrst_after");
`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1, 1, 1);
    frame(8'h07, 1, 0, 1);
    settle("parity");
`endif
    for (int i = 0; i < 24; i++) begin
      b    = 8'($urandom);
      s_ok = $urandom_range(0, 4) != 0;
      p_ok = $urandom_range(0, 4) != 0;
      rdy  = $urandom_range(0, 3) != 0;
      frame(b, s_ok, p_ok, rdy);
      tick(4 + $urandom_range(0, 20));
      if (!model_full) settle("rnd");
    end
    rx_ready = 1'b1;
    model_full = 1'b0;
    tick(2);
    settle("rnd_end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel 8N1 UART receiver; the receive end of the board's UART link, paired with the existing transmitter.
- Runs on the same oversampling clock as the transmitter. Transmitter bit period is 193 clocks (counter 0..192).
- Delivers bytes through a single-entry valid/ready output buffer. Consumers are a command decoder or the display/ADC logic.

Parameters:
- CLKS_PER_BIT, 193, clocks per serial bit; must be ≥ 4.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous rx input; must be ≥ 2.

Ports:
- clk  input  1  oversampling clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte, LSB received first.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: byte completed while the buffer was still full; new byte dropped.
- parity_err  output  1  one-cycle pulse: parity mismatch. Tied 0 when parity is disabled.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset low, asynchronous): FSM to IDLE; bit counter and clock counter 0; rx_data 8'h00; rx_valid, frame_err, overrun_err, parity_err, busy all 0; synchronizer flops preset to 1.
- Synchronizer: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, PARITY (only when parity is enabled), STOP.
- IDLE: a low rx_s moves to START and clears the clock counter.
- START: at count HALF = CLKS_PER_BIT/2 (integer division), re-sample rx_s.
  - Still low: clear the counter and go to DATA.
  - High: treat as a glitch and return to IDLE. No error flag.
- DATA: sample when the counter reaches CLKS_PER_BIT-1, which is mid-bit.
  - Shift rx_s into the shift register MSB; register shifts right.
  - After 8 samples go to PARITY or STOP.
- PARITY: sample one bit at mid-bit, then go to STOP.
- STOP: sample at mid-bit, then return to IDLE on that same edge. A new start edge may be detected on the very next cycle.
- Stop-sample outcomes:
  - rx_s low: pulse frame_err; byte discarded; rx_valid unchanged.
  - Parity mismatch: pulse parity_err; byte discarded.
  - Otherwise, if rx_valid==0 or rx_ready==1 in that cycle: load rx_data and set rx_valid=1.
  - Otherwise: pulse overrun_err; rx_data keeps the old byte.
- Latency: rx_valid rises 1 clk after the stop-bit mid-sample edge, i.e. the registered output.
- Handshake:
  - rx_valid falls on the clock after an accept (rx_valid && rx_ready), unless a new byte loads in that same cycle; then it stays 1 with the new data.
  - rx_data is stable while rx_valid=1 and not accepted.
- Line held low (break): appears as 0x00 plus frame_err. The receiver then waits in IDLE until rx_s goes high and then low again. It must not re-trigger on a continuous low.
- Clock counter width: $clog2(CLKS_PER_BIT). Wraps to 0 at CLKS_PER_BIT-1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. An even-parity bit follows data bit 7 and the PARITY state is present. parity_err pulses when the XOR of the 8 data bits and the parity bit is not 0.
- Undefined: frame is 8N1. There is no PARITY state; DATA goes directly to STOP. parity_err is driven constant 0.

Decomposition:
- Shared package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam DEFAULT_CLKS_PER_BIT = 193;
  - UART_DATA_BITS = 8.
- The transmitter is to be migrated to the same package.
- Natural sub-module: uart_sync, a parameterized N-flop synchronizer with a reset preset to 1. The FSM, counters and output buffer stay in uart_rx.

Test Plan (bench uses CLKS_PER_BIT=16):
- Send 0x55, then 0xA3, with rx_ready=1 → rx_valid pulses twice, carrying 0x55 then 0xA3; no error flags.
- Send a 5-clk low glitch on an idle line → no rx_valid; busy high then back to 0 within 8 clk; FSM back in IDLE.
- Send 0x3C with the stop bit forced low → frame_err one-cycle pulse; rx_valid stays 0.
- Hold rx_ready=0, send 0x11 then 0x22 → rx_data=0x11, rx_valid=1, overrun_err pulses once. After raising rx_ready, rx_valid drops and no 0x22 is delivered.
- Assert reset mid-byte (after data bit 3) and release, then send 0x7E → only 0x7E is delivered; outputs all 0 during reset.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 → rx_data 0x07. Send 0x07 with parity bit 0 → parity_err pulse, no rx_valid.
